// File: rtl/encoder_arbiter.sv
// Four-requester round-robin arbiter with one-hot and encoded grant outputs.
// A grant is held until done, request withdrawal, or the MAX_HOLD cycle limit.
module encoder_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic [1:0] num,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] num_q, num_d;
  logic       busy_q, busy_d;
  logic       timeout_q, timeout_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;

  // Requests rotated so that bit 0 is the requester the pointer favours.
  logic [3:0] rot_req;
  logic [1:0] win_off;
  logic [1:0] win;
  logic       rel_c;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rot
      assign rot_req[gi] = req[ptr_q + 2'(gi)];
    end
  endgenerate

  always_comb begin
    win_off = 2'd0;
    casez (rot_req)
      4'b???1: win_off = 2'd0;
      4'b??10: win_off = 2'd1;
      4'b?100: win_off = 2'd2;
      4'b1000: win_off = 2'd3;
      default: win_off = 2'd0;
    endcase
    win = ptr_q + win_off;
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    num_d     = num_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    rel_c     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_GRANT;
          grant_d = 4'b0001 << win;
          num_d   = win;
          busy_d  = 1'b1;
          cnt_d   = 8'd0;
        end
      end
      ST_GRANT: begin
        // done outranks the hold limit, so a coincident done never flags timeout.
        if (done) begin
          rel_c = 1'b1;
        end else if (!req[num_q]) begin
          rel_c = 1'b1;
        end else if (cnt_q == HOLD_LAST) begin
          rel_c     = 1'b1;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
        if (rel_c) begin
          state_d = ST_IDLE;
          grant_d = 4'b0000;
          busy_d  = 1'b0;
          cnt_d   = 8'd0;
          ptr_d   = num_q + 2'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= 4'b0000;
      num_q     <= 2'd0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      ptr_q     <= 2'd0;
      cnt_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      num_q     <= num_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign grant   = grant_q;
  assign num     = num_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_encoder_arbiter.sv
// Directed bench for encoder_arbiter: reset, rotation, hold limit,
// withdrawal, done/limit collision and reset mid-grant.
module tb_encoder_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] num;
  logic       busy;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  encoder_arbiter #(.MAX_HOLD(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .grant   (grant),
    .num     (num),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] e_grant, input logic [1:0] e_num,
                         input logic e_busy, input logic e_to);
    $display("step %-14s req=%b done=%b grant=%b num=%0d busy=%b timeout=%b",
             tag, req, done, grant, num, busy, timeout);
    chk({tag, ".grant"},   8'(grant),   8'(e_grant));
    chk({tag, ".num"},     8'(num),     8'(e_num));
    chk({tag, ".busy"},    8'(busy),    8'(e_busy));
    chk({tag, ".timeout"}, 8'(timeout), 8'(e_to));
  endtask

  logic [3:0] rot_grant [5];
  logic [1:0] rot_num   [5];

  initial begin
    rot_grant[0] = 4'b1000; rot_num[0] = 2'd3;
    rot_grant[1] = 4'b0001; rot_num[1] = 2'd0;
    rot_grant[2] = 4'b0010; rot_num[2] = 2'd1;
    rot_grant[3] = 4'b0100; rot_num[3] = 2'd2;
    rot_grant[4] = 4'b1000; rot_num[4] = 2'd3;

    // Reset with requests and done asserted.
    rst = 1'b1; req = 4'b1111; done = 1'b1;
    tick(); chk_out("reset0", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick(); chk_out("reset1", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0; req = 4'b0000; done = 1'b0;
    tick(); chk_out("idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Single requester 2, released by done; pointer moves to 3.
    req = 4'b0100;
    tick(); chk_out("single_gnt", 4'b0100, 2'd2, 1'b1, 1'b0);
    tick(); chk_out("single_hold", 4'b0100, 2'd2, 1'b1, 1'b0);
    done = 1'b1;
    tick(); chk_out("single_rel", 4'b0000, 2'd2, 1'b0, 1'b0);
    done = 1'b0; req = 4'b1111;

    // Rotation with all requesting; first winner confirms ptr=3.
    for (int i = 0; i < 5; i++) begin
      tick(); chk_out("rot_gnt", rot_grant[i], rot_num[i], 1'b1, 1'b0);
      done = 1'b1;
      tick(); chk_out("rot_rel", 4'b0000, rot_num[i], 1'b0, 1'b0);
      done = 1'b0;
    end

    // Hold limit: ptr=0, only requester 1 asks, held exactly 8 cycles.
    req = 4'b0010;
    tick(); chk_out("hold_gnt", 4'b0010, 2'd1, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick(); chk_out("hold_cyc", 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    tick(); chk_out("hold_limit", 4'b0000, 2'd1, 1'b0, 1'b1);
    tick(); chk_out("hold_regnt", 4'b0010, 2'd1, 1'b1, 1'b0);
    req = 4'b0000;
    tick(); chk_out("hold_drop", 4'b0000, 2'd1, 1'b0, 1'b0);

    // Withdrawal: ptr=2, requester 3 wins, drops after 2 cycles.
    req = 4'b1000;
    tick(); chk_out("wd_gnt", 4'b1000, 2'd3, 1'b1, 1'b0);
    req = 4'b1001;  // other requesters are ignored mid-hold
    tick(); chk_out("wd_hold1", 4'b1000, 2'd3, 1'b1, 1'b0);
    tick(); chk_out("wd_hold2", 4'b1000, 2'd3, 1'b1, 1'b0);
    req = 4'b0000;
    tick(); chk_out("wd_rel", 4'b0000, 2'd3, 1'b0, 1'b0);

    // Collision: done on the hold-limit edge gives no timeout. ptr=0.
    req = 4'b0001;
    tick(); chk_out("col_gnt", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick(); chk_out("col_cyc", 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    done = 1'b1;
    tick(); chk_out("col_rel", 4'b0000, 2'd0, 1'b0, 1'b0);
    // done in IDLE is ignored.
    req = 4'b0000;
    tick(); chk_out("idle_done", 4'b0000, 2'd0, 1'b0, 1'b0);
    done = 1'b0;

    // Reset mid-grant: ptr=1, requester 2 granted, then reset.
    req = 4'b0100;
    tick(); chk_out("rm_gnt", 4'b0100, 2'd2, 1'b1, 1'b0);
    rst = 1'b1;
    tick(); chk_out("rm_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0; req = 4'b1111;
    tick(); chk_out("rm_regnt", 4'b0001, 2'd0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
